// File: rtl/fence_t_sequencer.sv
// Temporal-fence sequencer: halts commit, flushes N targets, waits out external
// transactions, pulses the uarch clear and keeps the resume PC across that clear.
module fence_t_sequencer #(
    parameter int unsigned NrTargets     = 2,
    parameter int unsigned ClrCycles     = 16,
    parameter int unsigned TimeoutCycles = 0,
    parameter int unsigned VLEN          = 64,
    parameter int unsigned ResumeOffset  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 fence_t_req_i,
    input  logic [VLEN-1:0]      pc_commit_i,
    input  logic [VLEN-1:0]      boot_addr_i,
    output logic [NrTargets-1:0] flush_o,
    input  logic [NrTargets-1:0] flush_ack_i,
    input  logic [NrTargets-1:0] busy_i,
    output logic                 fence_t_clr_o,
    output logic                 halt_o,
    output logic [VLEN-1:0]      rst_addr_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FLUSH      = 2'd1,
        WAIT_TRANS = 2'd2,
        RST_UARCH  = 2'd3
    } state_t;

    localparam int unsigned ClrW   = $clog2(ClrCycles);
    localparam int unsigned WdW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [ClrW-1:0] ClrLast = ClrW'(ClrCycles - 1);
    localparam logic [WdW-1:0]  WdLast  = WdW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic            WdEn    = (TimeoutCycles > 0);

    state_t                state_q, state_d;
    logic [NrTargets-1:0]  flush_q, flush_d;
    logic [NrTargets-1:0]  ack_seen_q, ack_seen_d;
    logic [ClrW-1:0]       clr_cnt_q, clr_cnt_d;
    logic [WdW-1:0]        wd_cnt_q, wd_cnt_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic [VLEN-1:0]       rst_addr_q, rst_addr_d;
    logic                  wd_expired;

    // Handshake: flush_o[i] is a level request held high until the target
    // returns a one-cycle flush_ack_i[i]; the ack is consumed only in FLUSH and
    // only once per target, later or repeated acks are dropped.
    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        ack_seen_d = ack_seen_q;
        clr_cnt_d  = clr_cnt_q;
        wd_cnt_d   = wd_cnt_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        rst_addr_d = rst_addr_q;
        wd_expired = WdEn && (wd_cnt_q == WdLast);

        case (state_q)
            IDLE: begin
                if (fence_t_req_i) begin
                    rst_addr_d = pc_commit_i + VLEN'(ResumeOffset);
                    flush_d    = '1;
                    ack_seen_d = '0;
                    wd_cnt_d   = '0;
                    state_d    = FLUSH;
                end
            end
            FLUSH: begin
                ack_seen_d = ack_seen_q | flush_ack_i;
                flush_d    = flush_q & ~flush_ack_i;
                if (WdEn) wd_cnt_d = wd_cnt_q + 1'b1;
                if (&ack_seen_d) begin
                    state_d   = (|busy_i) ? WAIT_TRANS : RST_UARCH;
                    clr_cnt_d = '0;
                end else if (wd_expired) begin
                    flush_d   = '0;
                    timeout_d = 1'b1;
                    clr_cnt_d = '0;
                    state_d   = RST_UARCH;
                end
            end
            WAIT_TRANS: begin
                if (WdEn) wd_cnt_d = wd_cnt_q + 1'b1;
                if (busy_i == '0) begin
                    state_d   = RST_UARCH;
                    clr_cnt_d = '0;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    clr_cnt_d = '0;
                    state_d   = RST_UARCH;
                end
            end
            RST_UARCH: begin
                if (clr_cnt_q == ClrLast) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = '0;
            end
        endcase
    end

    // The resume address deliberately ignores clr_i so it outlives the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            flush_q    <= '0;
            ack_seen_q <= '0;
            clr_cnt_q  <= '0;
            wd_cnt_q   <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            rst_addr_q <= boot_addr_i;
        end else if (clr_i) begin
            state_q    <= IDLE;
            flush_q    <= '0;
            ack_seen_q <= '0;
            clr_cnt_q  <= '0;
            wd_cnt_q   <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            ack_seen_q <= ack_seen_d;
            clr_cnt_q  <= clr_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            rst_addr_q <= rst_addr_d;
        end
    end

    assign flush_o       = flush_q;
    assign fence_t_clr_o = (state_q == RST_UARCH);
    assign halt_o        = (state_q != IDLE);
    assign rst_addr_o    = rst_addr_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign state_o       = state_q;

endmodule
